// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state type and AR channel constants for the DMA read arbiter
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] AR_BURST_INCR  = 2'd1;
    localparam logic [2:0] AR_SIZE_8B     = 3'd3;
    localparam int         AR_LEN_DEFAULT = 15;

endpackage

// File: rtl/dma_read_arbiter_rr_arb2.sv
// rtl/dma_read_arbiter_rr_arb2.sv - combinational two-way round-robin pick with one-hot winner
module rr_arb2
    import dma_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] win
);

    // On contention the requester that was not served last wins; a lone request wins outright
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dma_read_arbiter.sv
// rtl/dma_read_arbiter.sv - round-robin sharing of one AR/R read port between two DMA engines (option: DMA_ARB_WDOG_EN)
module dma_read_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 64,
    parameter int LEN_W       = 8,
    parameter int WDOG_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rq0_ARVALID,
    input  logic [ADDR_W-1:0] rq0_ARADDR,
    input  logic [LEN_W-1:0]  rq0_ARLENGTH,
    input  logic [1:0]        rq0_ARBURST,
    input  logic [2:0]        rq0_ARSIZE,
    output logic              rq0_ARREADY,
    output logic [DATA_W-1:0] rq0_RDATA,
    output logic              rq0_RVALID,
    input  logic              rq0_RREADY,
    input  logic              rq1_ARVALID,
    input  logic [ADDR_W-1:0] rq1_ARADDR,
    input  logic [LEN_W-1:0]  rq1_ARLENGTH,
    input  logic [1:0]        rq1_ARBURST,
    input  logic [2:0]        rq1_ARSIZE,
    output logic              rq1_ARREADY,
    output logic [DATA_W-1:0] rq1_RDATA,
    output logic              rq1_RVALID,
    input  logic              rq1_RREADY,
    output logic              ARVALID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLENGTH,
    output logic [1:0]        ARBURST,
    output logic [2:0]        ARSIZE,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [1:0]        grant,
    output logic              wdog_err
);

    import dma_pkg::*;

    // beats_left is one bit wider than ARLENGTH so a 256-beat burst never wraps
    localparam logic [LEN_W:0] ONE_BEAT = {{LEN_W{1'b0}}, 1'b1};

    arb_state_t        state;
    logic              last_gnt;
    logic [LEN_W:0]    beats_left;
    logic [1:0]        win;
    logic              g1;
    logic              r_hs;
    logic              last_beat;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [1:0]        sel_burst;
    logic [2:0]        sel_size;

    rr_arb2 u_rr_arb2 (
        .req      ({rq1_ARVALID, rq0_ARVALID}),
        .last_gnt (last_gnt),
        .win      (win)
    );

    assign g1        = grant[1];
    assign sel_addr  = win[1] ? rq1_ARADDR   : rq0_ARADDR;
    assign sel_len   = win[1] ? rq1_ARLENGTH : rq0_ARLENGTH;
    assign sel_burst = win[1] ? rq1_ARBURST  : rq0_ARBURST;
    assign sel_size  = win[1] ? rq1_ARSIZE   : rq0_ARSIZE;

    // Only the owner sees the shared handshakes; the other side is held off
    assign rq0_ARREADY = (state == ADDR) && grant[0] && ARREADY;
    assign rq1_ARREADY = (state == ADDR) && grant[1] && ARREADY;
    assign RREADY      = (state == DATA) && (g1 ? rq1_RREADY : rq0_RREADY);
    assign rq0_RVALID  = (state == DATA) && grant[0] && RVALID;
    assign rq1_RVALID  = (state == DATA) && grant[1] && RVALID;
    assign rq0_RDATA   = RDATA;
    assign rq1_RDATA   = RDATA;

    assign r_hs      = RVALID && RREADY;
    assign last_beat = r_hs && (beats_left == ONE_BEAT);

`ifdef DMA_ARB_WDOG_EN
    logic [31:0] wdog_cnt;
    logic        wdog_hit;

    assign wdog_hit = (state == DATA) && !r_hs && (wdog_cnt == 32'(WDOG_CYCLES - 1));
`else
    logic wdog_unused;

    assign wdog_unused = (WDOG_CYCLES != 0);
    assign wdog_err    = 1'b0;
`endif

    // Arbitration FSM: latch winner's address phase, hold AR until accepted, then own R until the last beat
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            ARVALID    <= 1'b0;
            ARADDR     <= '0;
            ARLENGTH   <= LEN_W'(AR_LEN_DEFAULT);
            ARBURST    <= AR_BURST_INCR;
            ARSIZE     <= AR_SIZE_8B;
            grant      <= 2'b00;
            beats_left <= '0;
            last_gnt   <= 1'b1;
`ifdef DMA_ARB_WDOG_EN
            wdog_cnt   <= '0;
            wdog_err   <= 1'b0;
`endif
        end else begin
`ifdef DMA_ARB_WDOG_EN
            wdog_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|win) begin
                        ARVALID    <= 1'b1;
                        ARADDR     <= sel_addr;
                        ARLENGTH   <= sel_len;
                        ARBURST    <= sel_burst;
                        ARSIZE     <= sel_size;
                        grant      <= win;
                        beats_left <= {1'b0, sel_len} + ONE_BEAT;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        state   <= DATA;
`ifdef DMA_ARB_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beats_left <= beats_left - ONE_BEAT;
                        if (last_beat) begin
                            state    <= IDLE;
                            grant    <= 2'b00;
                            last_gnt <= g1;
                        end
                    end
`ifdef DMA_ARB_WDOG_EN
                    if (r_hs) begin
                        wdog_cnt <= '0;
                    end else if (wdog_hit) begin
                        state    <= IDLE;
                        grant    <= 2'b00;
                        last_gnt <= g1;
                        wdog_err <= 1'b1;
                        wdog_cnt <= '0;
                    end else begin
                        wdog_cnt <= wdog_cnt + 32'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
